// File: rtl/enc_if_pkg.sv
// Shared constants for the registered 4-input priority encoder.
//   Y_W         width of the request vector
//   A_W         width of the encoded output {multi, valid, idx}
//   IDX_W       width of the index field A[1:0]
//   A_VALID_BIT position of the "any request" flag in A
//   A_MULTI_BIT position of the "two or more requests" flag in A
package enc_if_pkg;

    localparam int Y_W         = 4;
    localparam int A_W         = 4;
    localparam int IDX_W       = 2;
    localparam int A_VALID_BIT = 2;
    localparam int A_MULTI_BIT = 3;

endpackage : enc_if_pkg

// File: rtl/enc_if_prio_comb.sv
// Combinational core of the priority encoder.
// Ports:
//   Y     in   [3:0]  request vector, Y[3] has the highest priority
//   idx   out  [1:0]  index of the highest-priority set bit (0 when Y == 0)
//   valid out         at least one request set
//   multi out         two or more requests set
module enc_if_prio_comb
    import enc_if_pkg::*;
(
    input  logic [Y_W-1:0]   Y,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             multi
);

    logic [2:0] req_cnt;

    always_comb begin
        idx = '0;
        if (Y[3]) begin
            idx = 2'd3;
        end else if (Y[2]) begin
            idx = 2'd2;
        end else if (Y[1]) begin
            idx = 2'd1;
        end else if (Y[0]) begin
            idx = 2'd0;
        end else begin
            idx = 2'd0;
        end
    end

    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < Y_W; i++) begin
            req_cnt = req_cnt + 3'(Y[i]);
        end
    end

    assign valid = |Y;
    // multi can only be set when valid is, since it needs at least two bits.
    assign multi = (req_cnt >= 3'd2);

endmodule : enc_if_prio_comb

// File: rtl/enc_if_reg.sv
// Registered 4-input priority encoder. One cycle of latency from Y to A,
// no combinational path from Y to A.
// Ports:
//   clk    in         system clock, rising edge active
//   rst_n  in         synchronous active-low reset, clears A
//   Y      in   [3:0] request vector, Y[3] has the highest priority
//   A      out  [3:0] registered code {multi, valid, idx[1:0]}
module enc_if_reg
    import enc_if_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [Y_W-1:0] Y,
    output logic [A_W-1:0] A
);

    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             multi;
    logic [A_W-1:0]   a_next;

    enc_if_prio_comb u_prio (
        .Y     (Y),
        .idx   (idx),
        .valid (valid),
        .multi (multi)
    );

    always_comb begin
        a_next              = '0;
        a_next[IDX_W-1:0]   = idx;
        a_next[A_VALID_BIT] = valid;
        a_next[A_MULTI_BIT] = multi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A <= '0;
        end else begin
            A <= a_next;
        end
    end

endmodule : enc_if_reg

// File: tb/tb_enc_if_reg.sv
// Scoreboard bench for enc_if_reg: the driver pushes the expected A for each
// applied (rst_n, Y) pair, the monitor pops and compares one cycle later.
module tb_enc_if_reg;

    logic       clk;
    logic       rst_n;
    logic [3:0] Y;
    logic [3:0] A;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_exp;
    bit         done = 0;

    enc_if_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Y     (Y),
        .A     (A)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: highest set bit gives the index, popcount gives the flags.
    function automatic logic [3:0] ref_model(input logic rst, input logic [3:0] y);
        int          n;
        logic [1:0]  ix;
        n  = $countones(y);
        ix = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (y[b]) ix = 2'(b);
        end
        if (!rst) return 4'b0000;
        return {(n >= 2), (n >= 1), ix};
    endfunction

    task automatic drive(input logic rst, input logic [3:0] y);
        @(posedge clk);
        #2;
        rst_n = rst;
        Y     = y;
        exp_q.push_back(ref_model(rst, y));
    endtask

    task automatic check_now(input string name, input logic [3:0] exp);
        checks++;
        if (A !== exp) begin
            errors++;
            $display("FAIL %s: A=%b expected %b", name, A, exp);
        end
    endtask

    // Monitor: every edge with an outstanding expectation produces one compare.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            checks++;
            if (A !== last_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: A=%b expected %b", $time, A, last_exp);
            end
        end
    end

    initial begin
        logic [3:0] directed [8];
        directed = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0000, 4'b0011, 4'b0110, 4'b1010};
        rst_n = 1'b0;
        Y     = 4'b0000;

        // Reset wins over a pending request, release gives 0111.
        drive(1'b0, 4'b1000);
        drive(1'b1, 4'b1000);

        foreach (directed[i]) drive(1'b1, directed[i]);
        drive(1'b1, 4'b1111);

        // Exhaustive ascending sweep, one value per 20 ns cycle.
        for (int v = 0; v < 16; v++) drive(1'b1, 4'(v));

        // Mid-stream reset and release.
        drive(1'b1, 4'b0110);
        drive(1'b0, 4'b1111);
        drive(1'b1, 4'b0101);
        drive(1'b1, 4'b0101);

        // Latency: a mid-cycle change of Y must not reach A before the edge.
        drive(1'b1, 4'b1000);
        @(posedge clk);
        #5;
        check_now("latency_before_change", 4'b0111);
        Y = 4'b0001;
        exp_q.push_back(ref_model(1'b1, 4'b0001));
        #3;
        check_now("latency_after_change", 4'b0111);

        // Randomized traffic with occasional reset pulses.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL watchdog: run did not complete, expected completion before 200000");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule : tb_enc_if_reg
